// File: rtl/video_pkg.sv
// Shared timing defaults, FSM state type and small helpers for the video fetch block.
package video_pkg;

    localparam logic [14:0] FB_BASE_DEF        = 15'h4000;
    localparam int          H_ACTIVE_BYTES_DEF = 40;
    localparam int          V_ACTIVE_DEF       = 200;
    localparam int          V_TOTAL_DEF        = 262;
    localparam int          VSYNC_START_DEF    = 234;
    localparam int          VSYNC_LEN_DEF      = 3;
    localparam int          HSYNC_START_DEF    = 44;
    localparam int          HSYNC_LEN_DEF      = 4;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_BLANK  = 1'b1
    } video_state_e;

    // True when pos lies in the half-open window [start, start+len).
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/video_shifter.sv
// Byte-wide load / serial-out shift register; MSB leaves first, zeros fill from the right.
module video_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift_en,
    input  logic [7:0] data,
    output logic       serial_out
);

    logic [7:0] shift_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= 8'h00;
        end else if (load) begin
            shift_reg <= data;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
        end
    end

    assign serial_out = shift_reg[7];

endmodule

// File: rtl/video_fetch.sv
// Framebuffer fetch, pixel serialisation and sync generation driven by an external h counter.
// Define VIDEO_FETCH_DOUBLE_SCAN_EN to show every framebuffer row on two consecutive scanlines.
module video_fetch
    import video_pkg::*;
#(
    parameter logic [14:0] FB_BASE        = FB_BASE_DEF,
    parameter int          H_ACTIVE_BYTES = H_ACTIVE_BYTES_DEF,
    parameter int          V_ACTIVE       = V_ACTIVE_DEF,
    parameter int          V_TOTAL        = V_TOTAL_DEF,
    parameter int          VSYNC_START    = VSYNC_START_DEF,
    parameter int          VSYNC_LEN      = VSYNC_LEN_DEF,
    parameter int          HSYNC_START    = HSYNC_START_DEF,
    parameter int          HSYNC_LEN      = HSYNC_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  h_low,
    input  logic        h_end,
    output logic        mem_rd,
    output logic [14:0] mem_addr,
    input  logic [7:0]  mem_d_in,
    output logic        pixel,
    output logic        active,
    output logic        hsync,
    output logic        vsync
);

    localparam int                LINE_W    = $clog2(V_TOTAL);
    localparam logic [5:0]        H_BYTES   = 6'(H_ACTIVE_BYTES);
    localparam logic [14:0]       REWIND    = 15'(H_ACTIVE_BYTES);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_TOTAL - 1);
    localparam logic [LINE_W-1:0] ACT_LINES = LINE_W'(V_ACTIVE);

    video_state_e      state_reg, state_next;
    logic [5:0]        slot_reg, slot_next;
    logic [LINE_W-1:0] line_reg, line_next;
    logic [14:0]       addr_reg, addr_next;
    logic              rd_dly_reg, rd_dly_next;
    logic [7:0]        data_reg, data_next;
    logic [2:0]        phase;
    logic              fetch, rewind, shifter_clear, shift_out;
    logic [1:0]        unused_h_low;

    assign phase        = h_low[2:0];
    assign unused_h_low = h_low[4:3];

`ifdef VIDEO_FETCH_DOUBLE_SCAN_EN
    // Even active lines hand their row back so the following odd line repeats it.
    assign rewind = (state_reg == ST_ACTIVE) && !line_reg[0];
`else
    assign rewind = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_ACTIVE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fetch      = 1'b0;
        if (h_end) begin
            state_next = (line_next < ACT_LINES) ? ST_ACTIVE : ST_BLANK;
        end
        case (state_reg)
            ST_ACTIVE: fetch = !reset && (slot_reg < H_BYTES) && (phase == 3'd0);
            default:   fetch = 1'b0;
        endcase
    end

    always_comb begin
        slot_next   = slot_reg;
        line_next   = line_reg;
        addr_next   = addr_reg;
        rd_dly_next = fetch;
        data_next   = data_reg;
        if (phase == 3'd7) begin
            slot_next = slot_reg + 6'd1;
        end
        // Read data is valid the clk after the strobe; slots without a fetch display blank.
        if (phase == 3'd1) begin
            data_next = rd_dly_reg ? mem_d_in : 8'h00;
        end
        if (fetch) begin
            addr_next = addr_reg + 15'd1;
        end
        if (h_end) begin
            slot_next   = '0;
            rd_dly_next = 1'b0;
            data_next   = 8'h00;
            line_next   = (line_reg == LAST_LINE) ? '0 : line_reg + LINE_W'(1);
            if (rewind) begin
                addr_next = addr_next - REWIND;
            end
            if (line_reg == LAST_LINE) begin
                addr_next = FB_BASE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg   <= '0;
            line_reg   <= '0;
            addr_reg   <= FB_BASE;
            rd_dly_reg <= 1'b0;
            data_reg   <= 8'h00;
        end else begin
            slot_reg   <= slot_next;
            line_reg   <= line_next;
            addr_reg   <= addr_next;
            rd_dly_reg <= rd_dly_next;
            data_reg   <= data_next;
        end
    end

    // A line ending mid-slot throws away whatever byte was still waiting to be shown.
    assign shifter_clear = reset | h_end;

    video_shifter u_shifter (
        .clk       (clk),
        .reset     (shifter_clear),
        .load      (phase == 3'd7),
        .shift_en  (1'b1),
        .data      (data_reg),
        .serial_out(shift_out)
    );

    assign mem_rd   = fetch;
    assign mem_addr = addr_reg;
    assign active   = (state_reg == ST_ACTIVE) && (slot_reg >= 6'd1) && (slot_reg <= H_BYTES);
    assign pixel    = active & shift_out;
    assign hsync    = in_window(int'(slot_reg), HSYNC_START, HSYNC_LEN);
    assign vsync    = in_window(int'(line_reg), VSYNC_START, VSYNC_LEN);

endmodule

// File: tb/tb_video_fetch.sv
// Randomised line lengths and SRAM contents checked every clk against a position-based model.
module tb_video_fetch;

    localparam logic [14:0] FB = 15'h4000;
    localparam int H  = 40;
    localparam int VA = 200;
    localparam int VT = 262;
    localparam int NL = 300;

    logic        clk = 1'b0;
    logic        reset, h_end, mem_rd, pixel, active, hsync, vsync;
    logic [4:0]  h_low;
    logic [14:0] mem_addr;
    logic [7:0]  mem_d_in;

    video_fetch dut (
        .clk     (clk),
        .reset   (reset),
        .h_low   (h_low),
        .h_end   (h_end),
        .mem_rd  (mem_rd),
        .mem_addr(mem_addr),
        .mem_d_in(mem_d_in),
        .pixel   (pixel),
        .active  (active),
        .hsync   (hsync),
        .vsync   (vsync)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  sram [32768];
    int          hcnt, line_len, ml, abs_line;
    logic [14:0] m_addr;
    logic [14:0] fa [64];
    bit          check_en = 1'b0;
    logic        last_rd;
    logic [14:0] last_addr;

    int          rd_cnt [NL];
    int          act_cnt [NL];
    int          pix_cnt [NL];
    int          hs_cnt [NL];
    int          hs_min [NL];
    int          hs_max [NL];
    int          bad_phase [NL];
    logic [14:0] first_addr [NL];
    logic [14:0] last_addr_l [NL];
    logic [7:0]  byte0;
    int          byte0_cnt;
    int          vs_lines, vs_min, vs_max, vs_last_line;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int choose_len();
        if (abs_line < 3 || abs_line >= VT) return 512;
        if (ml == 210) return 512;
        if (ml < VA) begin
            if ($urandom_range(0, 1) == 1) return 328 + int'($urandom_range(0, 7));
            return int'($urandom_range(9, 327));
        end
        return int'($urandom_range(8, 31));
    endfunction

    // Advance one clk: update the reference model for the cycle just ended, then drive inputs.
    task automatic step();
        logic e_fetch;
        int   slot;
        @(posedge clk);
        #1;
        slot = hcnt / 8;
        if (reset) begin
            ml       = 0;
            abs_line = 0;
            m_addr   = FB;
            if (h_end) begin
                hcnt     = 0;
                line_len = choose_len();
            end else begin
                hcnt++;
            end
        end else begin
            e_fetch = (ml < VA) && (slot < H) && (hcnt % 8 == 0);
            if (e_fetch) begin
                fa[slot] = m_addr;
                m_addr   = m_addr + 15'd1;
            end
            if (h_end) begin
`ifdef VIDEO_FETCH_DOUBLE_SCAN_EN
                if (ml < VA && ml % 2 == 0) m_addr = m_addr - 15'(H);
`endif
                if (ml == VT - 1) m_addr = FB;
                ml       = (ml + 1) % VT;
                abs_line++;
                hcnt     = 0;
                line_len = choose_len();
            end else begin
                hcnt++;
            end
        end
        h_low    = 5'(hcnt);
        h_end    = (hcnt == line_len - 1);
        mem_d_in = last_rd ? sram[last_addr] : 8'($urandom);
    endtask

    always @(negedge clk) begin
        int          slot, ph;
        logic        e_rd, e_act, e_pix, e_hs, e_vs;
        logic [14:0] e_addr;
        last_rd   = mem_rd;
        last_addr = mem_addr;
        if (check_en) begin
            slot   = hcnt / 8;
            ph     = hcnt % 8;
            e_rd   = (ml < VA) && (slot < H) && (ph == 0);
            e_addr = e_rd ? m_addr : 15'h0;
            e_act  = (ml < VA) && (slot >= 1) && (slot <= H);
            e_pix  = 1'b0;
            if (e_act) e_pix = sram[fa[slot-1]][7-ph];
            e_hs   = (slot >= 44) && (slot < 48);
            e_vs   = (ml >= 234) && (ml < 237);
            check($sformatf("cycle line=%0d pos=%0d {rd,addr,pix,act,hs,vs}", ml, hcnt),
                  {mem_rd, (mem_rd ? mem_addr : 15'h0), pixel, active, hsync, vsync},
                  {e_rd, e_addr, e_pix, e_act, e_hs, e_vs});
            if (abs_line < NL) begin
                if (mem_rd) begin
                    if (rd_cnt[abs_line] == 0) first_addr[abs_line] = mem_addr;
                    last_addr_l[abs_line] = mem_addr;
                    rd_cnt[abs_line]++;
                    if (h_low[2:0] != 3'd0) bad_phase[abs_line]++;
                end
                if (active) act_cnt[abs_line]++;
                if (pixel)  pix_cnt[abs_line]++;
                if (hsync) begin
                    hs_cnt[abs_line]++;
                    if (slot < hs_min[abs_line]) hs_min[abs_line] = slot;
                    if (slot > hs_max[abs_line]) hs_max[abs_line] = slot;
                end
            end
            if (abs_line == 0 && slot == 1) begin
                byte0 = {byte0[6:0], pixel};
                if (active) byte0_cnt++;
            end
            if (vsync && abs_line < VT && ml != vs_last_line) begin
                vs_lines++;
                vs_last_line = ml;
                if (ml < vs_min) vs_min = ml;
                if (ml > vs_max) vs_max = ml;
            end
        end
    end

    initial begin
        logic got_rd;
        for (int i = 0; i < 32768; i++) sram[i] = 8'($urandom);
        sram[15'h4000] = 8'hA5;
        for (int i = 0; i < NL; i++) begin
            rd_cnt[i] = 0; act_cnt[i] = 0; pix_cnt[i] = 0; hs_cnt[i] = 0;
            hs_min[i] = 1000; hs_max[i] = -1; bad_phase[i] = 0;
            first_addr[i] = 15'h0; last_addr_l[i] = 15'h0;
        end
        byte0 = 8'h00; byte0_cnt = 0;
        vs_lines = 0; vs_min = 1000; vs_max = -1; vs_last_line = -1;

        reset = 1'b1; hcnt = 504; line_len = 512; ml = 0; abs_line = 0; m_addr = FB;
        h_low = 5'(hcnt); h_end = 1'b0; mem_d_in = 8'h00;
        repeat (3) step();
        @(negedge clk);
        check("reset mem_rd", mem_rd, 0);
        check("reset mem_addr", mem_addr, 15'h4000);
        check("reset pixel", pixel, 0);
        check("reset active", active, 0);
        check("reset hsync", hsync, 0);
        check("reset vsync", vsync, 0);
        while (!h_end) step();
        step();
        reset    = 1'b0;
        check_en = 1'b1;

        while (abs_line < VT + 3) step();

        check("line0 slot1 pixels", byte0, 8'hA5);
        check("line0 slot1 active clks", byte0_cnt, 8);
        check("line0 fetch count", rd_cnt[0], 40);
        check("line0 first addr", first_addr[0], 15'h4000);
        check("line0 last addr", last_addr_l[0], 15'h4027);
        check("line0 off-phase reads", bad_phase[0], 0);
        check("line0 hsync clks", hs_cnt[0], 32);
`ifdef VIDEO_FETCH_DOUBLE_SCAN_EN
        check("line1 first addr", first_addr[1], 15'h4000);
        check("line1 last addr", last_addr_l[1], 15'h4027);
        check("line2 first addr", first_addr[2], 15'h4028);
`else
        check("line1 first addr", first_addr[1], 15'h4028);
        check("line1 last addr", last_addr_l[1], 15'h404F);
        check("line2 first addr", first_addr[2], 15'h4050);
`endif
        check("vsync line count", vs_lines, 3);
        check("vsync first line", vs_min, 234);
        check("vsync last line", vs_max, 236);
        check("line210 reads", rd_cnt[210], 0);
        check("line210 active clks", act_cnt[210], 0);
        check("line210 pixel clks", pix_cnt[210], 0);
        check("line210 hsync clks", hs_cnt[210], 32);
        check("line210 hsync first slot", hs_min[210], 44);
        check("line210 hsync last slot", hs_max[210], 47);
        check("frame2 line0 first addr", first_addr[VT], 15'h4000);
        check("frame2 line0 fetch count", rd_cnt[VT], 40);

        // Reset in slot 10 of line 5, then confirm outputs and the restart address.
        while (!(ml == 5 && hcnt == 83)) step();
        check_en = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midline reset mem_rd", mem_rd, 0);
        check("midline reset mem_addr", mem_addr, 15'h4000);
        check("midline reset pixel", pixel, 0);
        check("midline reset active", active, 0);
        check("midline reset hsync", hsync, 0);
        check("midline reset vsync", vsync, 0);
        got_rd = 1'b0;
        for (int i = 0; i < 64 && !got_rd; i++) begin
            step();
            @(negedge clk);
            if (mem_rd) begin
                got_rd = 1'b1;
                check("post-reset fetch addr", mem_addr, 15'h4000);
            end
        end
        check("post-reset fetch seen", got_rd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
